// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer:
//   - PC_W                 : program counter width (32)
//   - RESET_VECTOR_DEFAULT : default PC loaded on reset
//   - PC_STEP              : sequential fetch increment (one 32-bit word)
//   - pc_state_t           : fetch sequencer states (IDLE, FETCH, STALL)
//   - next_seq_pc / jump_target / branch_target : address arithmetic helpers
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_STEP              = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_STALL = 2'b10
  } pc_state_t;

  // Sequential successor; wraps 32'hFFFF_FFFC -> 32'h0000_0000 naturally.
  function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

  // Jump target keeps the 256 MB region of the delay-slot PC.
  function automatic logic [PC_W-1:0] jump_target(input logic [3:0]  region,
                                                  input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

  // Branch offset is in words; the add wraps silently at 32 bits.
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc_plus4,
                                                    input logic [PC_W-1:0] sign_imm);
    return pc_plus4 + (sign_imm << 2);
  endfunction

endpackage

// File: rtl/pc_sequencer_target_calc.sv
// -----------------------------------------------------------------------------
// pc_target_calc
// Combinational redirect decode. Produces the taken flag and the redirect
// target from a branch/jump resolution. Jump wins over a branch; nothing is
// taken when i_resolve_valid is low.
// Ports:
//   i_resolve_valid    : resolution presented this cycle
//   i_resolve_pc_plus4 : PCPlus4 of the resolving instruction
//   i_branch, i_zero   : conditional branch, taken when both are high
//   i_sign_imm         : sign-extended branch offset in words
//   i_jump             : unconditional jump
//   i_jump_index       : 26-bit instr_index of the jump
//   o_taken            : a redirect is requested
//   o_target           : redirect target address (0 when not taken)
// -----------------------------------------------------------------------------
module pc_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic              i_resolve_valid,
  input  logic [PC_W-1:0]   i_resolve_pc_plus4,
  input  logic              i_branch,
  input  logic              i_zero,
  input  logic [PC_W-1:0]   i_sign_imm,
  input  logic              i_jump,
  input  logic [25:0]       i_jump_index,
  output logic              o_taken,
  output logic [PC_W-1:0]   o_target
);

  // Redirect decode with jump priority.
  always_comb begin
    o_taken  = 1'b0;
    o_target = 32'h0000_0000;
    if (i_resolve_valid) begin
      if (i_jump) begin
        o_taken  = 1'b1;
        o_target = jump_target(i_resolve_pc_plus4[31:28], i_jump_index);
      end else if (i_branch && i_zero) begin
        o_taken  = 1'b1;
        o_target = branch_target(i_resolve_pc_plus4, i_sign_imm);
      end else begin
        o_taken  = 1'b0;
        o_target = 32'h0000_0000;
      end
    end else begin
      o_taken  = 1'b0;
      o_target = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter and the fetch handshake toward instruction memory.
// Next PC on an accepted fetch is (in priority order) the buffered redirect,
// the redirect resolving this cycle, or PC+4. A taken redirect that cannot
// be applied immediately is held in a one-entry buffer; while that buffer is
// occupied further redirects are wrong-path and are dropped.
// Ports:
//   clk              : clock, rising edge
//   reset            : synchronous active-low reset
//   stall            : hold fetch, no new request is issued while high
//   fetch_valid      : PC is a valid fetch request (registered)
//   fetch_ready      : instruction memory accepts the request
//   PC               : current fetch address (registered)
//   PCPlus4          : PC + 4 (combinational from PC)
//   resolve_valid, resolve_pc_plus4, Branch, Zero, SignImm, Jump, JumpIndex :
//                      branch/jump resolution inputs
//   redirect_pending : redirect buffer occupied (registered)
//   taken_count      : saturating count of redirects that loaded PC
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  input  logic             resolve_valid,
  input  logic [31:0]      resolve_pc_plus4,
  input  logic             Branch,
  input  logic             Zero,
  input  logic [31:0]      SignImm,
  input  logic             Jump,
  input  logic [25:0]      JumpIndex,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pc_state_t         r_state;
  logic              r_fetch_valid;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_buf_target;
  logic              r_pending;
  logic [CNT_W-1:0]  r_taken_count;

  logic              w_taken;
  logic [PC_W-1:0]   w_target;
  logic [PC_W-1:0]   w_pc_plus4;
  logic              w_accept;
  logic              w_load_buf;
  logic              w_load_direct;
  logic              w_capture;
  logic [PC_W-1:0]   w_next_pc;

  pc_target_calc u_target_calc (
    .i_resolve_valid    (resolve_valid),
    .i_resolve_pc_plus4 (resolve_pc_plus4),
    .i_branch           (Branch),
    .i_zero             (Zero),
    .i_sign_imm         (SignImm),
    .i_jump             (Jump),
    .i_jump_index       (JumpIndex),
    .o_taken            (w_taken),
    .o_target           (w_target)
  );

  assign w_pc_plus4 = next_seq_pc(r_pc);

  // Accept qualification and next-PC selection.
  always_comb begin
    w_accept      = 1'b0;
    w_load_buf    = 1'b0;
    w_load_direct = 1'b0;
    w_capture     = 1'b0;
    w_next_pc     = w_pc_plus4;
    w_accept      = (r_state == ST_FETCH) && r_fetch_valid && fetch_ready;
    // The buffer holds the oldest redirect, so it always beats a new one.
    w_load_buf    = w_accept && r_pending;
    w_load_direct = w_accept && !r_pending && w_taken;
    // Only an empty buffer captures; anything later is wrong-path.
    w_capture     = !w_accept && w_taken && !r_pending;
    if (w_load_buf) begin
      w_next_pc = r_buf_target;
    end else if (w_load_direct) begin
      w_next_pc = w_target;
    end else begin
      w_next_pc = w_pc_plus4;
    end
  end

  // Fetch sequencer FSM with registered fetch_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_fetch_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (stall) begin
            r_state       <= ST_STALL;
            r_fetch_valid <= 1'b0;
          end else begin
            r_state       <= ST_FETCH;
            r_fetch_valid <= 1'b1;
          end
        end
        ST_FETCH: begin
          // Stall withdraws an unaccepted request and blocks the next one.
          if (stall) begin
            r_state       <= ST_STALL;
            r_fetch_valid <= 1'b0;
          end else begin
            r_state       <= ST_FETCH;
            r_fetch_valid <= 1'b1;
          end
        end
        ST_STALL: begin
          if (stall) begin
            r_state       <= ST_STALL;
            r_fetch_valid <= 1'b0;
          end else begin
            r_state       <= ST_FETCH;
            r_fetch_valid <= 1'b1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  // Program counter register; only moves on an accepted fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= RESET_VECTOR;
    end else if (w_accept) begin
      r_pc <= w_next_pc;
    end else begin
      r_pc <= r_pc;
    end
  end

  // One-entry redirect buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending    <= 1'b0;
      r_buf_target <= 32'h0000_0000;
    end else if (w_load_buf) begin
      r_pending    <= 1'b0;
      r_buf_target <= r_buf_target;
    end else if (w_capture) begin
      r_pending    <= 1'b1;
      r_buf_target <= w_target;
    end else begin
      r_pending    <= r_pending;
      r_buf_target <= r_buf_target;
    end
  end

  // Saturating count of redirects that actually loaded PC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_taken_count <= {CNT_W{1'b0}};
    end else if ((w_load_buf || w_load_direct) && (r_taken_count != CNT_MAX)) begin
      r_taken_count <= r_taken_count + CNT_ONE;
    end else begin
      r_taken_count <= r_taken_count;
    end
  end

  assign fetch_valid      = r_fetch_valid;
  assign PC               = r_pc;
  assign PCPlus4          = w_pc_plus4;
  assign redirect_pending = r_pending;
  assign taken_count      = r_taken_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed vector table, a counter-saturation sequence, and a randomized run
// compared against a behavioural model (queue-based redirect buffer).
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int          CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] RV      = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              fetch_valid;
  logic              fetch_ready;
  logic [31:0]       PC;
  logic [31:0]       PCPlus4;
  logic              resolve_valid;
  logic [31:0]       resolve_pc_plus4;
  logic              Branch;
  logic              Zero;
  logic [31:0]       SignImm;
  logic              Jump;
  logic [25:0]       JumpIndex;
  logic              redirect_pending;
  logic [CNT_W-1:0]  taken_count;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .fetch_valid      (fetch_valid),
    .fetch_ready      (fetch_ready),
    .PC               (PC),
    .PCPlus4          (PCPlus4),
    .resolve_valid    (resolve_valid),
    .resolve_pc_plus4 (resolve_pc_plus4),
    .Branch           (Branch),
    .Zero             (Zero),
    .SignImm          (SignImm),
    .Jump             (Jump),
    .JumpIndex        (JumpIndex),
    .redirect_pending (redirect_pending),
    .taken_count      (taken_count)
  );

  typedef struct {
    logic        rst_n;
    logic        stl;
    logic        rdy;
    logic        rv;
    logic        br;
    logic        z;
    logic        jmp;
    logic [31:0] rpp4;
    logic [31:0] simm;
    logic [25:0] jidx;
    logic        exp_fv;
    logic [31:0] exp_pc;
    logic        exp_pend;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_fv;
  logic [31:0] m_buf[$];
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic rst_n, input logic stl, input logic rdy, input logic rv,
                     input logic br, input logic z, input logic jmp, input logic [31:0] rpp4,
                     input logic [31:0] simm, input logic [25:0] jidx, input logic exp_fv,
                     input logic [31:0] exp_pc, input logic exp_pend, input int exp_cnt);
    vec_t v;
    v.rst_n = rst_n; v.stl = stl; v.rdy = rdy; v.rv = rv; v.br = br; v.z = z; v.jmp = jmp;
    v.rpp4 = rpp4; v.simm = simm; v.jidx = jidx; v.exp_fv = exp_fv; v.exp_pc = exp_pc;
    v.exp_pend = exp_pend; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst_n, input logic stl, input logic rdy, input logic rv,
                       input logic br, input logic z, input logic jmp, input logic [31:0] rpp4,
                       input logic [31:0] simm, input logic [25:0] jidx);
    reset = rst_n; stall = stl; fetch_ready = rdy; resolve_valid = rv; Branch = br;
    Zero = z; Jump = jmp; resolve_pc_plus4 = rpp4; SignImm = simm; JumpIndex = jidx;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    logic        taken;
    logic [31:0] tgt;
    taken = 1'b0;
    tgt   = 32'h0;
    if (resolve_valid && Jump) begin
      taken = 1'b1;
      tgt   = (resolve_pc_plus4 & 32'hF000_0000) | ({6'd0, JumpIndex} * 32'd4);
    end else if (resolve_valid && Branch && Zero) begin
      taken = 1'b1;
      tgt   = resolve_pc_plus4 + SignImm * 32'd4;
    end
    if (!reset) begin
      m_pc = RV; m_fv = 1'b0; m_buf.delete(); m_cnt = 0;
    end else begin
      if (m_fv && fetch_ready) begin
        if (m_buf.size() > 0) begin
          m_pc  = m_buf.pop_front();
          m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end else if (taken) begin
          m_pc  = tgt;
          m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end else if (taken && m_buf.size() == 0) begin
        m_buf.push_back(tgt);
      end
      m_fv = !stall;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0);

    //   rst  stl  rdy  rv   br   z    jmp  rpp4           simm           jidx          fv   pc             pend cnt
    add(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b0,32'h0,         1'b0,0);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h0,         1'b0,0);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h4,         1'b0,0);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h8,         1'b0,0);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'hC,         1'b0,0);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h10,        1'b0,0);
    add(1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,32'h10,        32'h3,         26'h0,       1'b1,32'h1C,        1'b0,1);
    add(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,32'h4,         32'h0,         26'h4,       1'b1,32'h10,        1'b0,2);
    add(1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,32'h10,        32'h3,         26'h0,       1'b1,32'h14,        1'b0,2);
    add(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h1000_0004, 32'h0,         26'h40,      1'b1,32'h14,        1'b1,2);
    add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h14,        1'b1,2);
    add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h14,        1'b1,2);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h1000_0100, 1'b0,3);
    add(1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h100,       32'h40,        26'h0,       1'b1,32'h1000_0100, 1'b1,3);
    add(1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h100,       32'h80,        26'h0,       1'b1,32'h1000_0100, 1'b1,3);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h200,       1'b0,4);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h204,       1'b0,4);
    add(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,32'h4,         32'h0,         26'h10,      1'b1,32'h40,        1'b0,5);
    add(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b0,32'h40,        1'b0,5);
    add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h40,        1'b0,5);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h44,        1'b0,5);
    add(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h0,         32'h0,         26'h100,     1'b1,32'h44,        1'b1,5);
    add(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b0,32'h0,         1'b0,0);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h0,         1'b0,0);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h4,         1'b0,0);
    add(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,32'hF000_0000, 32'h0,         26'h3FF_FFFF,1'b1,32'hFFFF_FFFC, 1'b0,1);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h0,         1'b0,1);
    add(1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,32'h4,         32'hFFFF_FFFE, 26'h0,       1'b1,32'hFFFF_FFFC, 1'b0,2);
    add(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b0,32'h0,         1'b0,2);
    add(1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,32'h20,        32'h4,         26'h0,       1'b0,32'h0,         1'b1,2);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h0,         1'b1,2);
    add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         26'h0,       1'b1,32'h30,        1'b0,3);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].stl, vecs[i].rdy, vecs[i].rv, vecs[i].br, vecs[i].z,
            vecs[i].jmp, vecs[i].rpp4, vecs[i].simm, vecs[i].jidx);
      @(posedge clk); #1;
      check($sformatf("vec%0d_fv", i), 32'(fetch_valid), 32'(vecs[i].exp_fv));
      check($sformatf("vec%0d_pc", i), PC, vecs[i].exp_pc);
      check($sformatf("vec%0d_pcplus4", i), PCPlus4, vecs[i].exp_pc + 32'd4);
      check($sformatf("vec%0d_pend", i), 32'(redirect_pending), 32'(vecs[i].exp_pend));
      check($sformatf("vec%0d_cnt", i), 32'(taken_count), 32'(vecs[i].exp_cnt));
    end

    // Counter saturation: back-to-back direct jumps starting from count 3.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 26'(i + 1));
      @(posedge clk); #1;
      check($sformatf("sat%0d_pc", i), PC, 32'((i + 1) * 4));
      check($sformatf("sat%0d_cnt", i), 32'(taken_count), 32'((4 + i < CNT_MAX) ? 4 + i : CNT_MAX));
    end

    // Randomized run against the behavioural model, starting from reset.
    for (int c = 0; c < 3000; c++) begin
      drive((c == 0) ? 1'b0 : ($urandom_range(0, 63) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) < 4), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
            $urandom, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom,
            26'($urandom));
      model_step();
      @(posedge clk); #1;
      check($sformatf("rnd%0d_fv", c), 32'(fetch_valid), 32'(m_fv));
      check($sformatf("rnd%0d_pc", c), PC, m_pc);
      check($sformatf("rnd%0d_pcplus4", c), PCPlus4, m_pc + 32'd4);
      check($sformatf("rnd%0d_pend", c), 32'(redirect_pending), 32'(m_buf.size() != 0));
      check($sformatf("rnd%0d_cnt", c), 32'(taken_count), 32'(m_cnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
